// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the bootloader byte-stream front end.
package boot_loader_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 9;

    localparam logic [7:0]       SYNC_BYTE_DEFAULT  = 8'hA5;
    localparam logic [CNT_W-1:0] LEN_ZERO_MEANS_256 = 9'd256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    // LEN byte to word count; a zero LEN byte encodes the maximum frame.
    function automatic logic [CNT_W-1:0] len_to_words(input logic [7:0] len);
        return (len == 8'd0) ? LEN_ZERO_MEANS_256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs payload bytes into little-endian 32-bit words; word_valid_o pulses
// for one cycle, the cycle after the 4th byte, with the full word on word_o.
module boot_word_packer
    import boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    logic [1:0]        lane_q;
    logic [DATA_W-1:0] word_q;
    logic              word_valid_q;

    // Drop each byte into its lane; flag the word once lane 3 is filled.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            lane_q       <= 2'd0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= byte_valid_i && (lane_q == 2'd3);
            if (byte_valid_i) begin
                word_q[{lane_q, 3'b000} +: 8] <= byte_i;
                lane_q                        <= lane_q + 2'd1;
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/boot_loader.sv
// Framed byte stream (SYNC, LEN, 4*N payload, CSUM) to RAM word writes.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | hunting for the sync byte, everything else discarded
// LEN     | next byte is the word count (0 means 256)
// DATA    | payload bytes; also takes CSUM if it follows the last byte
// CSUM    | waiting for the checksum byte
// DONE    | frame loaded, checksum good; held until restart
// ERR     | checksum bad or timed out; held until restart
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 8'd0,
    parameter logic [23:0]       TIMEOUT_CYCLES = 24'd12_000_000,
    parameter logic [7:0]        SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  word_count
);

    state_e            state_q;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  wc_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        sum_q;
    logic [23:0]       to_q;

    logic accept;
    logic csum_phase;
    logic payload_byte;
    logic timed_out;

    assign in_ready = (state_q != ST_DONE) && (state_q != ST_ERR);
    assign busy     = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERR);
    assign accept   = in_valid && in_ready;

    // The last word is being written this cycle, so a byte arriving now is
    // already the checksum even though the word counter has not caught up.
    assign csum_phase   = (state_q == ST_DATA) && wen && (wc_q == n_q - 9'd1);
    assign payload_byte = accept && (state_q == ST_DATA) && !csum_phase;
    assign timed_out    = (TIMEOUT_CYCLES != 24'd0) && !accept &&
                          (to_q == TIMEOUT_CYCLES - 24'd1);

    boot_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (accept && (state_q == ST_LEN)),
        .byte_valid_i (payload_byte),
        .byte_i       (in_data),
        .word_valid_o (wen),
        .word_o       (wdata)
    );

    // Frame FSM with checksum, address/word counters and idle timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            wc_q    <= '0;
            waddr_q <= BASE_ADDR;
            sum_q   <= 8'd0;
            to_q    <= 24'd0;
        end else begin
            if (wen) begin
                waddr_q <= waddr_q + 8'd1;
                wc_q    <= wc_q + 9'd1;
            end
            if (busy && !accept) begin
                to_q <= to_q + 24'd1;
            end else begin
                to_q <= 24'd0;
            end
            if (payload_byte) begin
                sum_q <= sum_q + in_data;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && (in_data == SYNC_BYTE)) state_q <= ST_LEN;
                end
                ST_LEN: begin
                    if (accept) begin
                        n_q     <= len_to_words(in_data);
                        sum_q   <= 8'd0;
                        waddr_q <= BASE_ADDR;
                        wc_q    <= '0;
                        state_q <= ST_DATA;
                    end else if (timed_out) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (csum_phase && accept) begin
                        state_q <= (in_data == sum_q) ? ST_DONE : ST_ERR;
                    end else if (timed_out) begin
                        state_q <= ST_ERR;
                    end else if (csum_phase) begin
                        state_q <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        state_q <= (in_data == sum_q) ? ST_DONE : ST_ERR;
                    end else if (timed_out) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (restart) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign waddr      = waddr_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: RAM writes are checked against a
// scoreboard queue filled as payload bytes are driven.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst, restart, in_valid;
    logic [7:0]  in_data;

    logic        in_ready0, wen0, busy0, done0, err0;
    logic [7:0]  waddr0;
    logic [31:0] wdata0;
    logic [8:0]  wc0;
    logic        in_ready1, wen1, busy1, done1, err1;
    logic [7:0]  waddr1;
    logic [31:0] wdata1;
    logic [8:0]  wc1;

    int          n_vec = 0;
    int          n_err = 0;
    int          wen_cnt = 0;
    logic        sel = 1'b0;
    logic [39:0] exp_q[$];
    logic [7:0]  payload[1024];

    always #5 clk = ~clk;

    boot_loader #(.BASE_ADDR(8'd0), .TIMEOUT_CYCLES(24'd16), .SYNC_BYTE(8'hA5)) dut0 (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .wen(wen0), .waddr(waddr0), .wdata(wdata0),
        .busy(busy0), .done(done0), .err(err0), .word_count(wc0)
    );

    boot_loader #(.BASE_ADDR(8'd250), .TIMEOUT_CYCLES(24'd16), .SYNC_BYTE(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .wen(wen1), .waddr(waddr1), .wdata(wdata1),
        .busy(busy1), .done(done1), .err(err1), .word_count(wc1)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor on the selected DUT
    always @(negedge clk) begin
        logic        w;
        logic [39:0] got;
        w   = sel ? wen1 : wen0;
        got = sel ? {waddr1, wdata1} : {waddr0, wdata0};
        if (w === 1'b1) begin
            wen_cnt++;
            check("wen_expected", 40'(exp_q.size() != 0), 40'd1);
            if (exp_q.size() != 0) check("write_addr_data", got, exp_q.pop_front());
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        clocks(1);
        restart = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        clocks(1);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int nw, input logic [7:0] csum_adj);
        logic [7:0] sum = 8'd0;
        send_byte(8'hA5);
        send_byte((nw == 256) ? 8'd0 : 8'(nw));
        for (int i = 0; i < 4 * nw; i++) begin
            sum = sum + payload[i];
            if (i % 4 == 3)
                exp_q.push_back({8'(base + 8'(i / 4)), payload[i], payload[i-1],
                                 payload[i-2], payload[i-3]});
            send_byte(payload[i]);
        end
        send_byte(sum + csum_adj);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"},    40'(wen0),      40'd0);
        check({tag, "_waddr"},  40'(waddr0),    40'd0);
        check({tag, "_wdata"},  40'(wdata0),    40'd0);
        check({tag, "_done"},   40'(done0),     40'd0);
        check({tag, "_err"},    40'(err0),      40'd0);
        check({tag, "_busy"},   40'(busy0),     40'd0);
        check({tag, "_wc"},     40'(wc0),       40'd0);
        check({tag, "_ready"},  40'(in_ready0), 40'd1);
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        clocks(2);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Good frame, two words
        for (int i = 0; i < 8; i++) payload[i] = 8'(8'h11 * (i + 1));
        send_frame(8'd0, 2, 8'd0);
        clocks(2);
        check("good_done",  40'(done0),      40'd1);
        check("good_err",   40'(err0),       40'd0);
        check("good_wc",    40'(wc0),        40'd2);
        check("good_ready", 40'(in_ready0),  40'd0);
        check("good_busy",  40'(busy0),      40'd0);
        check("good_sb",    40'(exp_q.size()), 40'd0);
        pulse_restart();
        check("restart_done",  40'(done0),     40'd0);
        check("restart_ready", 40'(in_ready0), 40'd1);
        check("restart_wc",    40'(wc0),       40'd2);

        // Bad checksum
        send_frame(8'd0, 2, 8'd1);
        clocks(2);
        check("badcs_err",   40'(err0),      40'd1);
        check("badcs_done",  40'(done0),     40'd0);
        check("badcs_ready", 40'(in_ready0), 40'd0);
        send_byte(8'hA5);
        clocks(1);
        check("badcs_hold_err",  40'(err0),  40'd1);
        check("badcs_hold_busy", 40'(busy0), 40'd0);
        check("badcs_sb",        40'(exp_q.size()), 40'd0);
        pulse_restart();
        check("badcs_restart_err", 40'(err0), 40'd0);

        // Leading junk
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("junk_busy", 40'(busy0), 40'd0);
        for (int i = 0; i < 4; i++) payload[i] = 8'(i + 1);
        send_frame(8'd0, 1, 8'd0);
        clocks(2);
        check("junk_done", 40'(done0), 40'd1);
        check("junk_wc",   40'(wc0),   40'd1);
        check("junk_sb",   40'(exp_q.size()), 40'd0);
        pulse_restart();

        // Timeout with a partial word pending
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
        clocks(15);
        check("to_early_err",  40'(err0),  40'd0);
        check("to_early_busy", 40'(busy0), 40'd1);
        clocks(1);
        check("to_err",  40'(err0),  40'd1);
        check("to_busy", 40'(busy0), 40'd0);
        check("to_wc",   40'(wc0),   40'd0);
        pulse_restart();

        // 256-word frame wrapping the address space on the second instance
        pulse_rst();
        for (int i = 0; i < 1024; i++) payload[i] = 8'($urandom_range(255));
        sel = 1'b1;
        wen_cnt = 0;
        send_frame(8'd250, 256, 8'd0);
        clocks(3);
        check("wrap_done",  40'(done1),   40'd1);
        check("wrap_err",   40'(err1),    40'd0);
        check("wrap_wc",    40'(wc1),     40'd256);
        check("wrap_wens",  40'(wen_cnt), 40'd256);
        check("wrap_waddr", 40'(waddr1),  40'd250);
        check("wrap_sb",    40'(exp_q.size()), 40'd0);
        sel = 1'b0;
        pulse_rst();

        // Reset mid-frame after the 6th payload byte
        for (int i = 0; i < 8; i++) payload[i] = 8'(8'h11 * (i + 1));
        send_byte(8'hA5);
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) exp_q.push_back({8'd0, payload[3], payload[2], payload[1], payload[0]});
            send_byte(payload[i]);
        end
        pulse_restart();
        check("midrst_restart_ignored", 40'(busy0), 40'd1);
        pulse_rst();
        check_reset_outputs("midrst");
        check("midrst_sb", 40'(exp_q.size()), 40'd0);
        send_frame(8'd0, 2, 8'd0);
        clocks(2);
        check("midrst_done", 40'(done0), 40'd1);
        check("midrst_wc",   40'(wc0),   40'd2);
        check("midrst_sb2",  40'(exp_q.size()), 40'd0);

        clocks(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
Byte-stream front end for the bootloader RAM. It accepts a framed byte stream from the board UART receiver and packs it into 32-bit little-endian words. It drives the RAM write port (wen/waddr/wdata) directly and reports load completion or error to the boot sequencer.

Parameters:
BASE_ADDR, 8'd0, first RAM word address written for each frame
TIMEOUT_CYCLES, 24'd12_000_000, max idle clk cycles between accepted bytes inside a frame; 0 disables timeout
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
restart  input  1  one-cycle pulse; leaves DONE/ERR and returns to IDLE
in_valid  input  1  byte available from UART receiver
in_data  input  8  received byte
in_ready  output  1  loader can accept a byte; transfer = in_valid & in_ready
wen  output  1  RAM write enable, one-cycle pulse per word
waddr  output  8  RAM word address
wdata  output  32  RAM write data
busy  output  1  frame in progress (LEN, DATA or CSUM)
done  output  1  frame loaded, checksum good; held until restart/rst
err  output  1  checksum mismatch or timeout; held until restart/rst
word_count  output  9  words written in current/last frame (0..256)

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-frame):
  - state=IDLE.
  - wen=0, waddr=BASE_ADDR, wdata=0, done=0, err=0, busy=0, word_count=0.
  - Byte lane counter, checksum and timeout counter cleared.
  - in_ready=1 after reset.
- Frame format: SYNC_BYTE, LEN, 4*N payload bytes, CSUM.
  - N = LEN, except LEN=0 means 256.
  - CSUM = 8-bit modular sum of the payload bytes only.
- States and transitions:
  - IDLE: in_ready=1. Accepted byte == SYNC_BYTE -> LEN. Any other byte is discarded; stay in IDLE.
  - LEN: on accept, latch N (9 bits), clear checksum and lane counter, waddr=BASE_ADDR, word_count=0 -> DATA.
  - DATA: on accept, byte k of a word goes to wdata[8k+7:8k] (k=0 first). Add the byte to the checksum.
    - On the 4th byte: wen=1 on the next cycle with the full word on wdata; waddr holds that word's address.
    - The cycle after the wen pulse, waddr increments mod 256 (wraps 255->0) and word_count increments.
    - When word_count reaches N -> CSUM.
  - CSUM: on accept, compare with the running checksum. Equal -> DONE (done=1); else -> ERR (err=1).
  - DONE/ERR: in_ready=0, outputs held. restart -> IDLE, clearing done/err; word_count is kept until the next LEN.
- busy=1 exactly in LEN, DATA and CSUM.
- Throughput: one byte per cycle sustained. in_ready stays 1 in IDLE/LEN/DATA/CSUM, so a wen pulse never stalls input.
- wen rules: never asserted in IDLE, LEN, CSUM, DONE or ERR. At most one pulse per 4 payload bytes.
- Timeout (TIMEOUT_CYCLES != 0):
  - Counter clears on every accepted byte and runs in LEN/DATA/CSUM.
  - Reaching TIMEOUT_CYCLES -> ERR. A partial word is never written.
- restart while busy: ignored. restart and rst together: rst wins.
- Overlapping payload wrap: writes continue at addresses mod 256. Loading 256 words from BASE_ADDR=8'd200 covers 200..255, then 0..199.

Decomposition:
- Package boot_loader_pkg:
  - State enum (IDLE, LEN, DATA, CSUM, DONE, ERR; 3-bit encoding).
  - SYNC_BYTE default, LEN_ZERO_MEANS_256 constant.
  - Width constants: ADDR_W=8, DATA_W=32, CNT_W=9.
- One sub-module, boot_word_packer:
  - 2-bit lane counter and 32-bit shift/lane register.
  - Produces word_valid and word.
  - Cleared by the FSM on LEN.
- FSM, checksum, address/word counters and timeout stay in boot_loader.

Test Plan:
- Good frame, N=2, BASE_ADDR=0: A5 02 11 22 33 44 55 66 77 88 CSUM=0x64 -> two wen pulses, (waddr 0, wdata 32'h44332211) then (waddr 1, wdata 32'h88776655); done=1, err=0, word_count=2.
- Bad checksum: same frame with CSUM=0x65 -> both words written, err=1, done=0, in_ready=0 until restart.
- Leading junk: 00 FF 5A before A5 01 01 02 03 04 0A -> junk ignored; one write (waddr 0, wdata 32'h04030201); done=1.
- Timeout: TIMEOUT_CYCLES=16, send A5 01 01 02 then idle 16 cycles -> err=1, no wen asserted.
- LEN=0 wrap: BASE_ADDR=8'd250, 256 words with correct CSUM -> 256 wen pulses, waddr sequence 250..255,0..249; word_count=256; done=1.
- Reset mid-frame: rst after the 6th payload byte -> all outputs at reset values next cycle; a new good frame then loads correctly from BASE_ADDR.
